// File: rtl/sync_demux_2ch.sv
// sync_demux_2ch: splits a sync-framed 2-slot TDM word stream into two strobed outputs; SYNC_DEMUX_STATS_EN adds word/frame counters.
module sync_demux_2ch (
    input  logic        clk,
    input  logic        rst,
    input  logic        sync,
    input  logic [31:0] switch_clk_cycles,
    input  logic [15:0] din,
    output logic [15:0] ds1_out,
    output logic        ds1_valid,
    output logic [15:0] ds2_out,
    output logic        ds2_valid,
    output logic        locked,
    output logic        cfg_err
`ifdef SYNC_DEMUX_STATS_EN
    ,
    output logic [31:0] ds1_count,
    output logic [31:0] ds2_count,
    output logic [31:0] frame_count
`endif
);
    typedef enum logic [1:0] {IDLE, SLOT1, SLOT2, GAP} state_t;
    state_t      state, cur, nxt;
    logic [32:0] pos, cur_pos, nxt_pos, two_n;
    logic [31:0] n_lat, cur_n;
    logic        restart, bad_sync, slot1_end, slot2_end, take1, take2;
    assign restart  = sync && switch_clk_cycles != 32'd0;
    assign bad_sync = sync && switch_clk_cycles == 32'd0;
    // a valid sync makes the current cycle slot-1 word 1 of a fresh frame
    always_comb begin
        cur       = restart ? SLOT1 : state;
        cur_pos   = restart ? 33'd1 : pos;
        cur_n     = restart ? switch_clk_cycles : n_lat;
        two_n     = {cur_n, 1'b0};
        slot1_end = cur_pos == {1'b0, cur_n};
        slot2_end = cur_pos + 33'd1 == two_n;
        take1     = !bad_sync && cur == SLOT1;
        take2     = !bad_sync && cur == SLOT2;
        nxt       = bad_sync ? IDLE :
                    cur == SLOT1 ? (slot1_end ? (cur_n == 32'd1 ? GAP : SLOT2) : SLOT1) :
                    cur == SLOT2 ? (slot2_end ? GAP : SLOT2) :
                    cur == GAP ? SLOT1 : IDLE;
        nxt_pos   = (bad_sync || cur == IDLE) ? 33'd0 : cur == GAP ? 33'd1 : cur_pos + 33'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            n_lat     <= '0;
            ds1_out   <= '0;
            ds2_out   <= '0;
            ds1_valid <= 1'b0;
            ds2_valid <= 1'b0;
            locked    <= 1'b0;
            cfg_err   <= 1'b0;
`ifdef SYNC_DEMUX_STATS_EN
            ds1_count   <= '0;
            ds2_count   <= '0;
            frame_count <= '0;
`endif
        end else begin
            state     <= nxt;
            pos       <= nxt_pos;
            n_lat     <= cur_n;
            ds1_valid <= take1;
            ds2_valid <= take2;
            if (take1) ds1_out <= din;
            if (take2) ds2_out <= din;
            locked    <= restart ? 1'b1 : bad_sync ? 1'b0 : locked;
            cfg_err   <= cfg_err | bad_sync;
`ifdef SYNC_DEMUX_STATS_EN
            if (take1) ds1_count <= ds1_count + 32'd1;
            if (take2) ds2_count <= ds2_count + 32'd1;
            if (nxt == GAP && cur != GAP) frame_count <= frame_count + 32'd1;
`endif
        end
    end
endmodule

// File: tb/tb_sync_demux_2ch.sv
// tb_sync_demux_2ch: random and directed frames against a frame-index reference model.
module tb_sync_demux_2ch;
    logic        clk = 0, rst = 1, sync = 0;
    logic [31:0] switch_clk_cycles = 0;
    logic [15:0] din = 0;
    logic [15:0] ds1_out, ds2_out;
    logic        ds1_valid, ds2_valid, locked, cfg_err;
    int          n_vec = 0, n_err = 0;
    logic        m_act = 0, m_v1 = 0, m_v2 = 0, m_lock = 0, m_cfg = 0;
    logic [15:0] m_d1 = 0, m_d2 = 0;
    longint      m_n = 0, m_k = 0;
    logic [31:0] m_c1 = 0, m_c2 = 0, m_fc = 0;
`ifdef SYNC_DEMUX_STATS_EN
    logic [31:0] ds1_count, ds2_count, frame_count;
`endif

    sync_demux_2ch dut (
        .clk(clk), .rst(rst), .sync(sync), .switch_clk_cycles(switch_clk_cycles), .din(din),
        .ds1_out(ds1_out), .ds1_valid(ds1_valid), .ds2_out(ds2_out), .ds2_valid(ds2_valid),
        .locked(locked), .cfg_err(cfg_err)
`ifdef SYNC_DEMUX_STATS_EN
        , .ds1_count(ds1_count), .ds2_count(ds2_count), .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("ds1_valid", {31'd0, ds1_valid}, {31'd0, m_v1});
        check("ds2_valid", {31'd0, ds2_valid}, {31'd0, m_v2});
        check("ds1_out", {16'd0, ds1_out}, {16'd0, m_d1});
        check("ds2_out", {16'd0, ds2_out}, {16'd0, m_d2});
        check("locked", {31'd0, locked}, {31'd0, m_lock});
        check("cfg_err", {31'd0, cfg_err}, {31'd0, m_cfg});
        check("excl_valid", {31'd0, ds1_valid & ds2_valid}, 32'd0);
`ifdef SYNC_DEMUX_STATS_EN
        check("ds1_count", ds1_count, m_c1);
        check("ds2_count", ds2_count, m_c2);
        check("frame_count", frame_count, m_fc);
`endif
    endtask

    task automatic model_reset();
        m_act = 0; m_v1 = 0; m_v2 = 0; m_lock = 0; m_cfg = 0;
        m_d1 = 0; m_d2 = 0; m_n = 0; m_k = 0;
        m_c1 = 0; m_c2 = 0; m_fc = 0;
    endtask

    // frame of 2n cycles: index k<n is stream 1, k<2n-1 stream 2, last is the hold cycle
    task automatic step(input logic s, input logic [31:0] n, input logic [15:0] d);
        sync = s; switch_clk_cycles = n; din = d;
        m_v1 = 0; m_v2 = 0;
        if (s && n != 0) begin
            m_act = 1; m_n = longint'(n); m_k = 0; m_lock = 1;
        end else if (s) begin
            m_act = 0; m_lock = 0; m_cfg = 1;
        end
        if (m_act) begin
            if (m_k < m_n) begin m_v1 = 1; m_d1 = d; m_c1++; end
            else if (m_k < 2 * m_n - 1) begin m_v2 = 1; m_d2 = d; m_c2++; end
            if (m_k + 1 == 2 * m_n - 1) m_fc++;
            m_k = (m_k + 1) % (2 * m_n);
        end
        @(posedge clk); #1;
        sync = 0;
        check_all();
    endtask

    initial begin
        logic [31:0] nr;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 0;
        for (int i = 0; i < 4; i++) step(0, 32'd4, 16'($urandom));
        for (int i = 0; i < 16; i++) step(i == 0, 32'd4, 16'(i));
        for (int i = 0; i < 8; i++) step(i == 0, 32'd1, 16'($urandom));
        for (int i = 0; i < 5; i++) step(i == 0, 32'd0, 16'($urandom));
        for (int i = 0; i < 14; i++) step(i == 0, 32'd3, 16'($urandom));
        for (int i = 0; i < 20; i++) step(i == 0 || i == 6, 32'd5, 16'($urandom));
        for (int i = 0; i < 11; i++) step(i == 0, 32'd8, 16'($urandom));
        #2 rst = 1;
        model_reset();
        #1 check_all();
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 4; i++) step(0, 32'd8, 16'($urandom));
        for (int i = 0; i < 41; i++) step(i == 0, 32'd2, 16'($urandom));
        for (int i = 0; i < 6; i++) step(i == 0, 32'hFFFF_FFFF, 16'($urandom));
        nr = 32'd3;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) nr = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
            step($urandom_range(0, 19) == 0, nr, 16'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sync_demux_2ch.md
SYNC_DEMUX_2CH -- requirements
Module: sync_demux_2ch

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have port: clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: sync  input  1  one-cycle pulse marking the first slot-1 word of a frame.
REQ-005 SHALL have port: switch_clk_cycles  input  32  slot length N in clocks, matching the upstream multiplexer setting.
REQ-006 SHALL have port: din  input  16  time-multiplexed data word from the upstream mode-2 multiplexer.
REQ-007 SHALL have port: ds1_out  output  16  registered stream-1 word.
REQ-008 SHALL have port: ds1_valid  output  1  one-cycle strobe per ds1_out word.
REQ-009 SHALL have port: ds2_out  output  16  registered stream-2 word.
REQ-010 SHALL have port: ds2_valid  output  1  one-cycle strobe per ds2_out word.
REQ-011 SHALL have port: locked  output  1  high while frames are being tracked.
REQ-012 SHALL have port: cfg_err  output  1  sticky flag, set by a sync pulse while N=0.

Function
REQ-013 SHALL implement a state machine with states IDLE, SLOT1, SLOT2 and GAP, plus a 33-bit position counter pos.
REQ-014 SHALL handle sync in any state as follows.
- On a sync pulse with switch_clk_cycles≥1: latch N into n_lat, set pos=1, enter SLOT1 and set locked=1.
- The clock carrying sync is itself slot-1 word 1.
REQ-015 SHALL handle sync with switch_clk_cycles=0 as follows: enter IDLE, clear locked, set cfg_err; no valid strobes are issued.
REQ-016 SHALL, in SLOT1 for pos 1..n_lat, register din to ds1_out and pulse ds1_valid on the following cycle (latency 1 clock).
REQ-017 SHALL, in SLOT2 for pos n_lat+1..2·n_lat−1, register din to ds2_out and pulse ds2_valid on the following cycle.
REQ-018 SHALL treat pos=2·n_lat as the GAP state, where no strobe is issued, matching the upstream hold cycle.
REQ-019 SHALL, after GAP, set pos=1, re-enter SLOT1 and free-run the frames without a further sync.
REQ-020 SHALL, for n_lat=1, go SLOT1 (1 word) -> GAP (1 cycle) -> SLOT1, with SLOT2 skipped and no ds2_valid.
REQ-021 SHALL compute 2·n_lat in 33 bits so that it does not wrap for N up to 2^32−1.
REQ-022 SHALL apply a change of switch_clk_cycles only at the next sync; n_lat holds until then.
REQ-023 SHALL treat a sync pulse mid-frame as a restart: the current word is slot-1 word 1, and no strobe is issued for the aborted slot beyond those already issued.
REQ-024 SHALL never assert ds1_valid and ds2_valid in the same cycle.
REQ-025 SHALL hold ds1_out and ds2_out stable between strobes.
REQ-026 SHALL, in IDLE, ignore din and hold all strobes low.

Reset
REQ-027 SHALL, on rst=1, asynchronously set state=IDLE, pos=0, n_lat=0, ds1_out=0, ds2_out=0, ds1_valid=0, ds2_valid=0, locked=0 and cfg_err=0.
REQ-028 SHALL, after rst deasserts, remain in IDLE until the first valid sync.
REQ-029 SHALL discard any partial frame when reset is asserted mid-frame.

Configuration
REQ-030 SHALL provide the macro SYNC_DEMUX_STATS_EN.
- When defined: add outputs ds1_count[31:0], ds2_count[31:0] and frame_count[31:0].
- Each count increments with its strobe or on entry to GAP, wraps modulo 2^32, and is cleared by rst only.
REQ-031 SHALL, when SYNC_DEMUX_STATS_EN is undefined, omit those ports and counters entirely, with identical remaining behaviour.

Verification
REQ-032 SHALL cover: N=4, sync at cycle 0, din=cycle index -> ds1 words 0,1,2,3; ds2 words 4,5,6; no strobe for 7; ds1 words 8..11 follow.
REQ-033 SHALL cover: N=1 with sync -> ds1_valid every 2nd cycle, ds2_valid never, locked=1.
REQ-034 SHALL cover: N=0 with sync -> cfg_err=1, locked=0, no strobes; then N=3 with sync -> normal frames, cfg_err still 1.
REQ-035 SHALL cover: N=5, sync re-pulsed at frame position 7 -> that word appears on ds1_out, ds1_valid next cycle, ds2 sequence aborted.
REQ-036 SHALL cover: rst asserted mid-SLOT2 with N=8 -> all outputs 0 immediately (asynchronously); no strobes until the next sync.
REQ-037 SHALL cover: with SYNC_DEMUX_STATS_EN, N=2 over 10 frames -> ds1_count=20, ds2_count=10, frame_count=10.
